board_reveal_engine: RTL and testbench
======================================

Name: board_reveal_engine

Overview:
- Player-side reader of the minesweeper board. The board generator writes the board: bomb placement plus adjacent-bomb counts in a 9-bit-per-cell 8x8 array. This block reads that array back.
- Executes reveal and flag commands.
- A reveal of a zero-count cell triggers a breadth-first flood reveal.
- Publishes revealed/flag masks and lose/win status to the display path.

Parameters:
- ROWS, 8, board rows.
- COLS, 8, board columns.
- QDEPTH, 64, flood queue depth. Must be >= ROWS*COLS.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high; clears all state.
- board  input  9 x [7:0][7:0]  cell array. bit8 = bomb; bits3:0 = adjacent count 0..8; other bits ignored. Must be stable while busy=1.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE.
- cmd_op  input  1  0 = reveal, 1 = toggle flag.
- cmd_row  input  3  target row.
- cmd_col  input  3  target column.
- revealed  output  64  bit i set = cell i revealed; i = row*8+col.
- flagged  output  64  bit i set = cell i flagged.
- busy  output  1  high whenever state != IDLE, LOST or WON.
- cmd_done  output  1  one-cycle pulse at the end of each accepted command.
- game_over  output  1  sticky; a bomb was revealed.
- game_won  output  1  sticky; every non-bomb cell is revealed.

Behaviour:
- Reset values: revealed=0, flagged=0, cmd_done=0, game_over=0, game_won=0, busy=0, cmd_ready=1. Queue is emptied and state = IDLE. Reset asserted mid-flood aborts on the next edge with no partial result retained.
- Handshake: a command is accepted when cmd_valid && cmd_ready. The address and opcode are latched on that edge.
- FSM states: IDLE, CHECK, POP, NEIGH, FINISH, LOST, WON.
- IDLE -> CHECK on accept.
- CHECK, flag op:
  - Target unrevealed: toggle its flagged bit.
  - Target revealed: no change.
  - Next state FINISH.
- CHECK, reveal op, by case:
  - Target revealed or flagged: no change -> FINISH.
  - Target is a bomb: set its revealed bit and game_over -> LOST, with cmd_done pulsed in that same transition.
  - Count != 0: set its revealed bit -> FINISH.
  - Count == 0: set its revealed bit, push its index to the queue -> POP.
- POP:
  - Queue empty -> FINISH.
  - Otherwise pop the head into cur and clear nbr_idx -> NEIGH.
- NEIGH: one neighbour per cycle, nbr_idx 0..7. Offset order is (-1,-1),(-1,0),(-1,+1),(0,-1),(0,+1),(+1,-1),(+1,0),(+1,+1).
  - Out-of-bounds neighbours (no wrap-around) are skipped but still consume their cycle.
  - A neighbour that is in-bounds, unrevealed, unflagged and non-bomb gets its revealed bit set. If its count == 0, it is also pushed.
  - After nbr_idx = 7 -> POP.
- Each cell is pushed at most once: only unrevealed cells are pushed, and the push coincides with the reveal. The queue therefore cannot overflow at QDEPTH=64. Push and pop never occur in the same cycle.
- FINISH: pulse cmd_done.
  - If (revealed | bomb_mask) is all ones, set game_won -> WON.
  - Otherwise -> IDLE.
- LOST and WON are terminal. cmd_ready=0, outputs hold, and only reset exits.
- Latency, counted from the accept edge:
  - Non-flood command: cmd_done is asserted 2 cycles after accept (CHECK, then FINISH).
  - Flood: 2 + 9*Z + 1 cycles, where Z is the number of zero-count cells popped.
- cmd_valid is ignored while cmd_ready=0.
- Flagged cells are never auto-revealed by a flood.

Decomposition:
- Package buscaminas_pkg holds:
  - ROWS/COLS constants.
  - Cell field positions: BOMB_BIT=8, COUNT_MSB=3, COUNT_LSB=0.
  - State enum: reveal_state_t.
  - Neighbour offset table: 8 entries of signed 2-bit dr/dc.
  - index function row*COLS+col.
- One sub-module: cell_queue. It is a synchronous FIFO of QDEPTH x 6-bit indices with push, pop, head, empty and full; same clk/reset.

Test Plan:
- Bomb only at (0,0). Reveal (1,1), count 1 -> cmd_done 2 cycles after accept; revealed = 64'h200 (bit 9 only); game_over=0.
- Same board. Reveal (7,7) -> flood:
  - 60 zero cells popped; cmd_done at cycle 543.
  - revealed = all ones except bit 0.
  - game_won=1; cmd_ready stays 0.
- Same board. Reveal (0,0) -> game_over=1; revealed = 64'h1; further cmd_valid is ignored.
- Flag (0,0), then reveal (0,0) -> flagged bit 0 = 1, revealed unchanged, game_over=0.
- Flag (0,0) twice -> flagged bit 0 returns to 0.
- Start the (7,7) flood, assert reset at cycle 20 -> next edge: revealed=0, busy=0, cmd_ready=1.
- Bombs at (0,1), (1,0), (1,1). Reveal (0,0) -> only bit 0 revealed; no out-of-bounds access or wrap into row 7/col 7.

Source files
------------

// File: rtl/board_reveal_engine_pkg.sv
// -----------------------------------------------------------------------------
// buscaminas_pkg
// Shared definitions for the minesweeper player-side reveal engine:
//   - board geometry and index widths
//   - cell field positions inside each 9-bit board word
//   - command opcode and reveal FSM state enums
//   - neighbour offset table walked by the flood fill
//   - index() helper mapping (row, col) to the flat cell index row*COLS+col
// -----------------------------------------------------------------------------
package buscaminas_pkg;

    localparam int BOARD_ROWS = 8;
    localparam int BOARD_COLS = 8;
    localparam int NCELLS     = BOARD_ROWS * BOARD_COLS;
    localparam int ROW_W      = 3;
    localparam int COL_W      = 3;
    localparam int IDX_W      = ROW_W + COL_W;

    // Cell word layout: bit8 = bomb, bits3:0 = adjacent bomb count.
    localparam int CELL_W     = 9;
    localparam int BOMB_BIT   = 8;
    localparam int COUNT_MSB  = 3;
    localparam int COUNT_LSB  = 0;

    typedef logic [IDX_W-1:0] cell_idx_t;

    typedef enum logic {
        OP_REVEAL = 1'b0,
        OP_FLAG   = 1'b1
    } cmd_op_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        POP,
        NEIGH,
        FINISH,
        LOST,
        WON
    } reveal_state_t;

    typedef struct packed {
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } nbr_offset_t;

    // Row-major scan of the 3x3 neighbourhood, centre excluded.
    localparam nbr_offset_t NBR_OFFSETS [8] = '{
        '{dr: -2'sd1, dc: -2'sd1},
        '{dr: -2'sd1, dc:  2'sd0},
        '{dr: -2'sd1, dc:  2'sd1},
        '{dr:  2'sd0, dc: -2'sd1},
        '{dr:  2'sd0, dc:  2'sd1},
        '{dr:  2'sd1, dc: -2'sd1},
        '{dr:  2'sd1, dc:  2'sd0},
        '{dr:  2'sd1, dc:  2'sd1}
    };

    function automatic cell_idx_t index(input int row, input int col);
        return cell_idx_t'(row * BOARD_COLS + col);
    endfunction

endpackage

// File: rtl/board_reveal_engine_if.sv
// -----------------------------------------------------------------------------
// board_reveal_engine_if
// Command channel between the player controller (master) and the reveal
// engine (slave).
//   cmd_valid  master->slave  command request
//   cmd_op     master->slave  OP_REVEAL / OP_FLAG
//   cmd_row    master->slave  target row
//   cmd_col    master->slave  target column
//   cmd_ready  slave->master  engine idle and able to accept
//   cmd_done   slave->master  one-cycle pulse when an accepted command ends
// -----------------------------------------------------------------------------
interface board_reveal_engine_if;
    import buscaminas_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    cmd_op_t          cmd_op;
    logic [ROW_W-1:0] cmd_row;
    logic [COL_W-1:0] cmd_col;
    logic             cmd_done;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_col,
        input  cmd_ready, cmd_done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_col,
        output cmd_ready, cmd_done
    );

endinterface

// File: rtl/board_reveal_engine_cell_queue.sv
// -----------------------------------------------------------------------------
// cell_queue
// Synchronous FIFO of cell indices used as the breadth-first flood frontier.
//   clk, reset  system clock, synchronous active-high reset (empties queue)
//   push        write push_idx at the tail (ignored when full)
//   push_idx    cell index to enqueue
//   pop         drop the head entry (ignored when empty)
//   head        current head entry, valid while !empty
//   empty/full  occupancy flags
// -----------------------------------------------------------------------------
module cell_queue
    import buscaminas_pkg::*;
#(
    parameter int QDEPTH = 64
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  cell_idx_t push_idx,
    input  logic      pop,
    output cell_idx_t head,
    output logic      empty,
    output logic      full
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    cell_idx_t        mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(QDEPTH));
    assign head    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by count, so
    // stale contents are never observed and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_idx;
    end

endmodule

// File: rtl/board_reveal_engine.sv
// -----------------------------------------------------------------------------
// board_reveal_engine
// Player-side reader of the minesweeper board. Executes reveal / flag-toggle
// commands, flood-reveals from zero-count cells breadth-first, and publishes
// revealed/flag masks and lose/win status.
//   clk, reset   system clock, synchronous active-high reset
//   board        [row][col] 9-bit cells (bit8 bomb, bits3:0 count); held
//                stable while busy
//   cmd          command channel (slave side of board_reveal_engine_if)
//   revealed     bit row*8+col set when that cell is revealed
//   flagged      bit row*8+col set when that cell is flagged
//   busy         command in progress
//   game_over    sticky, a bomb was revealed
//   game_won     sticky, every non-bomb cell is revealed
// Internal index arithmetic assumes the 8x8 geometry of buscaminas_pkg.
// -----------------------------------------------------------------------------
module board_reveal_engine
    import buscaminas_pkg::*;
#(
    parameter int ROWS   = BOARD_ROWS,
    parameter int COLS   = BOARD_COLS,
    parameter int QDEPTH = 64
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [ROWS-1:0][COLS-1:0][CELL_W-1:0]  board,
    board_reveal_engine_if.slave                   cmd,
    output logic [ROWS*COLS-1:0]                   revealed,
    output logic [ROWS*COLS-1:0]                   flagged,
    output logic                                   busy,
    output logic                                   game_over,
    output logic                                   game_won
);

    reveal_state_t        state, state_nxt;
    cmd_op_t              op_q;
    logic [ROW_W-1:0]     row_q;
    logic [COL_W-1:0]     col_q;
    cell_idx_t            cur, cur_nxt;
    logic [2:0]           nbr_idx, nbr_nxt;
    logic [ROWS*COLS-1:0] revealed_nxt, flagged_nxt, bomb_mask;
    logic                 done_nxt, over_nxt, won_nxt;

    logic                 q_push, q_pop, q_empty, q_full_unused;
    cell_idx_t            q_push_idx, q_head;

    cell_idx_t            tgt_idx;
    logic                 tgt_bomb;
    logic [3:0]           tgt_count;

    int                   nr, nc;
    logic                 nbr_in;
    logic [ROW_W-1:0]     nbr_row;
    logic [COL_W-1:0]     nbr_col;
    cell_idx_t            nbr_cell_idx;
    logic                 nbr_bomb;
    logic [3:0]           nbr_count;
    logic [3:0]           board_unused;

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = !(state inside {IDLE, LOST, WON});

    assign tgt_idx   = index(int'(row_q), int'(col_q));
    assign tgt_bomb  = board[row_q][col_q][BOMB_BIT];
    assign tgt_count = board[row_q][col_q][COUNT_MSB:COUNT_LSB];

    always_comb begin
        bomb_mask    = '0;
        board_unused = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                bomb_mask[r*COLS+c] = board[r][c][BOMB_BIT];
                board_unused        = board_unused ^ board[r][c][BOMB_BIT-1:COUNT_MSB+1];
            end
        end
    end

    // Neighbour under inspection; out-of-range coordinates are masked by nbr_in
    // so a corner cell never wraps onto the opposite edge.
    always_comb begin
        nr     = int'(cur[IDX_W-1:COL_W]) + int'(NBR_OFFSETS[nbr_idx].dr);
        nc     = int'(cur[COL_W-1:0])     + int'(NBR_OFFSETS[nbr_idx].dc);
        nbr_in = (nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS);
    end

    assign nbr_row      = ROW_W'(nr);
    assign nbr_col      = COL_W'(nc);
    assign nbr_cell_idx = index(int'(nbr_row), int'(nbr_col));
    assign nbr_bomb     = board[nbr_row][nbr_col][BOMB_BIT];
    assign nbr_count    = board[nbr_row][nbr_col][COUNT_MSB:COUNT_LSB];

    cell_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (q_push),
        .push_idx (q_push_idx),
        .pop      (q_pop),
        .head     (q_head),
        .empty    (q_empty),
        .full     (q_full_unused)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        revealed_nxt = revealed;
        flagged_nxt  = flagged;
        cur_nxt      = cur;
        nbr_nxt      = nbr_idx;
        done_nxt     = 1'b0;
        over_nxt     = game_over;
        won_nxt      = game_won;
        q_push       = 1'b0;
        q_push_idx   = tgt_idx;
        q_pop        = 1'b0;

        unique case (state)
            IDLE: if (cmd.cmd_valid) state_nxt = CHECK;

            CHECK: begin
                if (op_q == OP_FLAG) begin
                    if (!revealed[tgt_idx]) flagged_nxt[tgt_idx] = !flagged[tgt_idx];
                    state_nxt = FINISH;
                end else if (revealed[tgt_idx] || flagged[tgt_idx]) begin
                    state_nxt = FINISH;
                end else if (tgt_bomb) begin
                    revealed_nxt[tgt_idx] = 1'b1;
                    over_nxt              = 1'b1;
                    done_nxt              = 1'b1;
                    state_nxt             = LOST;
                end else if (tgt_count != 4'd0) begin
                    revealed_nxt[tgt_idx] = 1'b1;
                    state_nxt             = FINISH;
                end else begin
                    revealed_nxt[tgt_idx] = 1'b1;
                    q_push                = 1'b1;
                    state_nxt             = POP;
                end
            end

            POP: begin
                if (q_empty) begin
                    state_nxt = FINISH;
                end else begin
                    q_pop     = 1'b1;
                    cur_nxt   = q_head;
                    nbr_nxt   = '0;
                    state_nxt = NEIGH;
                end
            end

            NEIGH: begin
                // Pushing only at the moment of reveal keeps each cell queued
                // at most once, so the queue never exceeds the cell count.
                if (nbr_in && !revealed[nbr_cell_idx] && !flagged[nbr_cell_idx] && !nbr_bomb) begin
                    revealed_nxt[nbr_cell_idx] = 1'b1;
                    if (nbr_count == 4'd0) begin
                        q_push     = 1'b1;
                        q_push_idx = nbr_cell_idx;
                    end
                end
                if (nbr_idx == 3'd7) state_nxt = POP;
                else                 nbr_nxt   = nbr_idx + 1'b1;
            end

            FINISH: begin
                done_nxt = 1'b1;
                if (&(revealed | bomb_mask)) begin
                    won_nxt   = 1'b1;
                    state_nxt = WON;
                end else begin
                    state_nxt = IDLE;
                end
            end

            LOST, WON: state_nxt = state;

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            revealed     <= '0;
            flagged      <= '0;
            cur          <= '0;
            nbr_idx      <= '0;
            op_q         <= OP_REVEAL;
            row_q        <= '0;
            col_q        <= '0;
            cmd.cmd_done <= 1'b0;
            game_over    <= 1'b0;
            game_won     <= 1'b0;
        end else begin
            state        <= state_nxt;
            revealed     <= revealed_nxt;
            flagged      <= flagged_nxt;
            cur          <= cur_nxt;
            nbr_idx      <= nbr_nxt;
            cmd.cmd_done <= done_nxt;
            game_over    <= over_nxt;
            game_won     <= won_nxt;
            if (state == IDLE && cmd.cmd_valid) begin
                op_q  <= cmd.cmd_op;
                row_q <= cmd.cmd_row;
                col_q <= cmd.cmd_col;
            end
        end
    end

endmodule

// File: tb/tb_board_reveal_engine.sv
// -----------------------------------------------------------------------------
// tb_board_reveal_engine
// Directed bench for board_reveal_engine. Each task drives one scenario and
// compares outputs against hand-derived values. Latency is counted in clock
// edges after the accept edge until cmd_done is seen high.
// -----------------------------------------------------------------------------
module tb_board_reveal_engine;
    import buscaminas_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [7:0][7:0][8:0]  board;
    logic [63:0]           revealed, flagged;
    logic                  busy, game_over, game_won;
    int                    n_cmp = 0;
    int                    n_bad = 0;

    // Bomb layouts: A = single bomb at (0,0); B = bombs at (0,1),(1,0),(1,1).
    localparam logic [63:0] BOMBS_A = 64'h0000_0000_0000_0001;
    localparam logic [63:0] BOMBS_B = 64'h0000_0000_0000_0302;

    board_reveal_engine_if cmd_if ();

    board_reveal_engine #(.ROWS(8), .COLS(8), .QDEPTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .board     (board),
        .cmd       (cmd_if),
        .revealed  (revealed),
        .flagged   (flagged),
        .busy      (busy),
        .game_over (game_over),
        .game_won  (game_won)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Builds the board from a bomb mask: counts of the 8 neighbours, with the
    // don't-care bits 7:4 filled with a pattern the engine must ignore.
    task automatic set_board(input logic [63:0] bombs);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            if (bombs[rr*8+cc]) cnt++;
                    end
                end
                board[r][c] = {bombs[r*8+c], 4'b1010, 4'(cnt)};
            end
        end
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Waits for ready, drives one command and returns right after its accept
    // edge. ok = 0 if ready never came.
    task automatic start_cmd(input cmd_op_t op, input logic [2:0] row, input logic [2:0] col,
                             output bit ok);
        int k = 0;
        while (cmd_if.cmd_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        ok = (k < 50);
        if (ok) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_op    = op;
            cmd_if.cmd_row   = row;
            cmd_if.cmd_col   = col;
            @(posedge clk); #1;
            cmd_if.cmd_valid = 1'b0;
        end
    endtask

    // Edges after accept until cmd_done is high; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        while (cmd_if.cmd_done !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 2000) lat = -1;
    endtask

    task automatic issue(input cmd_op_t op, input logic [2:0] row, input logic [2:0] col,
                         output int lat);
        bit ok;
        start_cmd(op, row, col, ok);
        if (ok) wait_done(lat);
        else    lat = -1;
    endtask

    // Holds cmd_valid for several cycles in a terminal state; returns how many
    // cmd_done pulses appeared.
    task automatic poke_terminal(output int pulses);
        pulses           = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_REVEAL;
        cmd_if.cmd_row   = 3'd7;
        cmd_if.cmd_col   = 3'd7;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (cmd_if.cmd_done === 1'b1) pulses++;
        end
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        set_board(BOMBS_A);
        do_reset();
        n_cmp++; if (revealed !== 64'h0) begin n_bad++; $display("FAIL reset_revealed: got %h want 0", revealed); end
        n_cmp++; if (flagged !== 64'h0) begin n_bad++; $display("FAIL reset_flagged: got %h want 0", flagged); end
        n_cmp++; if (cmd_if.cmd_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", cmd_if.cmd_done); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL reset_over: got %b want 0", game_over); end
        n_cmp++; if (game_won !== 1'b0) begin n_bad++; $display("FAIL reset_won: got %b want 0", game_won); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_if.cmd_ready); end
    endtask

    task automatic test_reveal_count();
        int lat;
        set_board(BOMBS_A);
        do_reset();
        issue(OP_REVEAL, 3'd1, 3'd1, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL count_latency: got %0d want 2", lat); end
        n_cmp++; if (revealed !== 64'h200) begin n_bad++; $display("FAIL count_revealed: got %h want 200", revealed); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL count_over: got %b want 0", game_over); end
        n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL count_ready: got %b want 1", cmd_if.cmd_ready); end
    endtask

    task automatic test_flood_win();
        int lat, pulses;
        set_board(BOMBS_A);
        do_reset();
        issue(OP_REVEAL, 3'd7, 3'd7, lat);
        n_cmp++; if (lat !== 543) begin n_bad++; $display("FAIL flood_latency: got %0d want 543", lat); end
        n_cmp++; if (revealed !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL flood_revealed: got %h want fffffffffffffffe", revealed); end
        n_cmp++; if (game_won !== 1'b1) begin n_bad++; $display("FAIL flood_won: got %b want 1", game_won); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL flood_over: got %b want 0", game_over); end
        poke_terminal(pulses);
        n_cmp++; if (cmd_if.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL won_ready: got %b want 0", cmd_if.cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL won_busy: got %b want 0", busy); end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL won_ignored: got %0d done pulses want 0", pulses); end
    endtask

    task automatic test_bomb();
        int lat, pulses;
        set_board(BOMBS_A);
        do_reset();
        issue(OP_REVEAL, 3'd0, 3'd0, lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL bomb_latency: got %0d want 1", lat); end
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL bomb_over: got %b want 1", game_over); end
        n_cmp++; if (revealed !== 64'h1) begin n_bad++; $display("FAIL bomb_revealed: got %h want 1", revealed); end
        poke_terminal(pulses);
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL lost_ignored: got %0d done pulses want 0", pulses); end
        n_cmp++; if (revealed !== 64'h1) begin n_bad++; $display("FAIL lost_hold: got %h want 1", revealed); end
        n_cmp++; if (cmd_if.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL lost_ready: got %b want 0", cmd_if.cmd_ready); end
        n_cmp++; if (game_won !== 1'b0) begin n_bad++; $display("FAIL lost_won: got %b want 0", game_won); end
    endtask

    task automatic test_flag();
        int lat;
        set_board(BOMBS_A);
        do_reset();
        issue(OP_FLAG, 3'd0, 3'd0, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL flag_latency: got %0d want 2", lat); end
        n_cmp++; if (flagged !== 64'h1) begin n_bad++; $display("FAIL flag_set: got %h want 1", flagged); end
        issue(OP_REVEAL, 3'd0, 3'd0, lat);
        n_cmp++; if (revealed !== 64'h0) begin n_bad++; $display("FAIL flag_protects: got %h want 0", revealed); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL flag_over: got %b want 0", game_over); end
        issue(OP_FLAG, 3'd0, 3'd0, lat);
        n_cmp++; if (flagged !== 64'h0) begin n_bad++; $display("FAIL flag_toggle: got %h want 0", flagged); end
        issue(OP_REVEAL, 3'd1, 3'd1, lat);
        issue(OP_FLAG, 3'd1, 3'd1, lat);
        n_cmp++; if (flagged !== 64'h0) begin n_bad++; $display("FAIL flag_revealed_cell: got %h want 0", flagged); end
        // A flagged zero cell blocks the flood there: 59 zeros popped.
        do_reset();
        issue(OP_FLAG, 3'd0, 3'd3, lat);
        issue(OP_REVEAL, 3'd7, 3'd7, lat);
        n_cmp++; if (lat !== 534) begin n_bad++; $display("FAIL flagflood_latency: got %0d want 534", lat); end
        n_cmp++; if (revealed !== 64'hFFFF_FFFF_FFFF_FFF6) begin n_bad++; $display("FAIL flagflood_revealed: got %h want fffffffffffffff6", revealed); end
        n_cmp++; if (game_won !== 1'b0) begin n_bad++; $display("FAIL flagflood_won: got %b want 0", game_won); end
        n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL flagflood_ready: got %b want 1", cmd_if.cmd_ready); end
    endtask

    task automatic test_reset_mid_flood();
        int lat;
        bit ok;
        set_board(BOMBS_A);
        do_reset();
        start_cmd(OP_REVEAL, 3'd7, 3'd7, ok);
        repeat (19) begin @(posedge clk); #1; end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midflood_busy: got %b want 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if (revealed !== 64'h0) begin n_bad++; $display("FAIL abort_revealed: got %h want 0", revealed); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", cmd_if.cmd_ready); end
        // Leftover queue entries would add extra 9-cycle pops.
        issue(OP_REVEAL, 3'd7, 3'd7, lat);
        n_cmp++; if (lat !== 543) begin n_bad++; $display("FAIL reflood_latency: got %0d want 543", lat); end
    endtask

    task automatic test_corner();
        int lat;
        set_board(BOMBS_B);
        do_reset();
        issue(OP_REVEAL, 3'd0, 3'd0, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL corner_latency: got %0d want 2", lat); end
        n_cmp++; if (revealed !== 64'h1) begin n_bad++; $display("FAIL corner_revealed: got %h want 1", revealed); end
        do_reset();
        issue(OP_REVEAL, 3'd7, 3'd7, lat);
        n_cmp++; if (lat !== 498) begin n_bad++; $display("FAIL cornerflood_latency: got %0d want 498", lat); end
        n_cmp++; if (revealed !== 64'hFFFF_FFFF_FFFF_FCFC) begin n_bad++; $display("FAIL cornerflood_revealed: got %h want fffffffffffffcfc", revealed); end
        n_cmp++; if (game_won !== 1'b0) begin n_bad++; $display("FAIL cornerflood_won: got %b want 0", game_won); end
        issue(OP_REVEAL, 3'd0, 3'd0, lat);
        n_cmp++; if (revealed !== 64'hFFFF_FFFF_FFFF_FCFD) begin n_bad++; $display("FAIL lastcell_revealed: got %h want fffffffffffffcfd", revealed); end
        n_cmp++; if (game_won !== 1'b1) begin n_bad++; $display("FAIL lastcell_won: got %b want 1", game_won); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL lastcell_over: got %b want 0", game_over); end
    endtask

    initial begin
        reset            = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_REVEAL;
        cmd_if.cmd_row   = 3'd0;
        cmd_if.cmd_col   = 3'd0;
        set_board(BOMBS_A);

        test_reset();
        test_reveal_count();
        test_flood_win();
        test_bomb();
        test_flag();
        test_reset_mid_flood();
        test_corner();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
